// File: rtl/multiport_regfile_pkg.sv
// Shared constants for the multiport register file: default geometry and
// the controller state encoding.
package multiport_regfile_pkg;

  localparam int DEF_WIDTH    = 32;
  localparam int DEF_DEPTH    = 32;
  localparam int DEF_NREAD    = 2;
  localparam int DEF_ZERO_REG = 1;

  typedef logic [0:0] state_t;
  localparam state_t ST_CLEAR = 1'b0;
  localparam state_t ST_READY = 1'b1;

endpackage

// File: rtl/multiport_regfile_if.sv
// Bus bundle for the multiport register file: clear request, write port,
// packed read ports and busy status.
interface multiport_regfile_if
  import multiport_regfile_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int NREAD = DEF_NREAD
);
  localparam int AW = $clog2(DEPTH);

  logic                   clear_req;
  logic                   wr_en;
  logic [AW-1:0]          wr_addr;
  logic [WIDTH-1:0]       wr_data;
  logic [NREAD-1:0]       rd_en;
  logic [NREAD*AW-1:0]    rd_addr;
  logic [NREAD*WIDTH-1:0] rd_data;
  logic [NREAD-1:0]       rd_valid;
  logic                   busy;

  modport master (
    output clear_req, wr_en, wr_addr, wr_data, rd_en, rd_addr,
    input  rd_data, rd_valid, busy
  );

  modport slave (
    input  clear_req, wr_en, wr_addr, wr_data, rd_en, rd_addr,
    output rd_data, rd_valid, busy
  );

endinterface

// File: rtl/multiport_regfile_read_port.sv
// One registered read port: range check, zero-register forcing, write-first
// bypass and the output data/valid registers.
module regfile_read_port #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 1,
  parameter int AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ready,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  input  logic             wr_commit,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [WIDTH-1:0] mem [DEPTH],
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid
);

  function automatic logic in_range(input logic [AW-1:0] a);
    return {1'b0, a} < (AW+1)'(DEPTH);
  endfunction

  logic [WIDTH-1:0] word_p0;
  logic [WIDTH-1:0] data_p1;
  logic             vld_p1;

  // wr_commit is already filtered for range and zero register, so the bypass
  // can never leak a dropped write onto the read data.
  always_comb begin
    word_p0 = '0;
    if (!in_range(rd_addr))
      word_p0 = '0;
    else if (ZERO_REG != 0 && rd_addr == '0)
      word_p0 = '0;
    else if (wr_commit && wr_addr == rd_addr)
      word_p0 = wr_data;
    else
      word_p0 = mem[rd_addr];
  end

  // p0 -> p1: registered read; data holds when the port is idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_p1 <= '0;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= rd_en && ready;
      if (rd_en && ready)
        data_p1 <= word_p0;
    end
  end

  assign rd_data  = data_p1;
  assign rd_valid = vld_p1;

endmodule

// File: rtl/multiport_regfile.sv
// Multiport register file: one shared write port (clear sequencer or user),
// NREAD independent registered read ports.
module multiport_regfile
  import multiport_regfile_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int NREAD    = DEF_NREAD,
  parameter int ZERO_REG = DEF_ZERO_REG
) (
  input logic               clk,
  input logic               rst,
  multiport_regfile_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH-1);

  function automatic logic in_range(input logic [AW-1:0] a);
    return {1'b0, a} < (AW+1)'(DEPTH);
  endfunction

  state_t           state;
  logic [AW-1:0]    clr_ptr;
  logic             ready;
  logic             wr_ok;
  logic             mem_we;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_data;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_word [NREAD];
  logic [NREAD-1:0] rd_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_CLEAR;
      clr_ptr <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          if (clr_ptr == LAST) begin
            state   <= ST_READY;
            clr_ptr <= '0;
          end else begin
            clr_ptr <= clr_ptr + 1'b1;
          end
        end
        ST_READY: begin
          if (bus.clear_req) begin
            state   <= ST_CLEAR;
            clr_ptr <= '0;
          end
        end
        default: begin
          state   <= ST_CLEAR;
          clr_ptr <= '0;
        end
      endcase
    end
  end

  assign ready    = (state == ST_READY);
  assign bus.busy = (state == ST_CLEAR);

  // Single storage write port: the clear sequencer owns it while busy.
  assign wr_ok    = ready && bus.wr_en && in_range(bus.wr_addr)
                    && !(ZERO_REG != 0 && bus.wr_addr == '0);
  assign mem_we   = !ready || wr_ok;
  assign mem_addr = ready ? bus.wr_addr : clr_ptr;
  assign mem_data = ready ? bus.wr_data : '0;

  always_ff @(posedge clk) begin
    if (mem_we)
      mem[mem_addr] <= mem_data;
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    regfile_read_port #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .ZERO_REG (ZERO_REG),
      .AW       (AW)
    ) u_port (
      .clk       (clk),
      .rst       (rst),
      .ready     (ready),
      .rd_en     (bus.rd_en[i]),
      .rd_addr   (bus.rd_addr[i*AW +: AW]),
      .wr_commit (wr_ok),
      .wr_addr   (bus.wr_addr),
      .wr_data   (bus.wr_data),
      .mem       (mem),
      .rd_data   (rd_word[i]),
      .rd_valid  (rd_vld[i])
    );
  end

  always_comb begin
    bus.rd_data = '0;
    for (int i = 0; i < NREAD; i++)
      bus.rd_data[i*WIDTH +: WIDTH] = rd_word[i];
  end

  assign bus.rd_valid = rd_vld;

endmodule

// File: tb/tb_multiport_regfile.sv
// Directed bench: a DEPTH=32 and a DEPTH=20 instance share one stimulus stream
// so range-dependent behaviour can be compared side by side.
module tb_multiport_regfile;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   ca, cb;

  multiport_regfile_if #(.WIDTH(32), .DEPTH(32), .NREAD(2)) bus_a ();
  multiport_regfile_if #(.WIDTH(32), .DEPTH(20), .NREAD(2)) bus_b ();

  assign bus_b.clear_req = bus_a.clear_req;
  assign bus_b.wr_en     = bus_a.wr_en;
  assign bus_b.wr_addr   = bus_a.wr_addr;
  assign bus_b.wr_data   = bus_a.wr_data;
  assign bus_b.rd_en     = bus_a.rd_en;
  assign bus_b.rd_addr   = bus_a.rd_addr;

  multiport_regfile #(.WIDTH(32), .DEPTH(32), .NREAD(2), .ZERO_REG(1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  multiport_regfile #(.WIDTH(32), .DEPTH(20), .NREAD(2), .ZERO_REG(1)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // All drive tasks start and end at posedge+1.
  task automatic do_write(input logic [4:0] addr, input logic [31:0] data);
    bus_a.wr_en   = 1'b1;
    bus_a.wr_addr = addr;
    bus_a.wr_data = data;
    @(posedge clk); #1;
    bus_a.wr_en   = 1'b0;
  endtask

  task automatic do_read(input logic [4:0] a0, input logic [4:0] a1, input logic [1:0] en);
    bus_a.rd_en   = en;
    bus_a.rd_addr = {a1, a0};
    @(posedge clk); #1;
    bus_a.rd_en   = 2'b00;
  endtask

  // Counts negedge samples with busy high; with inject set, pokes a write,
  // a read and a second clear_req into the running sequence.
  task automatic count_busy(input bit inject, output int na, output int nb);
    na = 0;
    nb = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus_a.busy) na++;
      if (bus_b.busy) nb++;
      if (inject) begin
        case (k)
          5: begin
            bus_a.wr_en   = 1'b1;
            bus_a.wr_addr = 5'd3;
            bus_a.wr_data = 32'hAAAA5555;
          end
          6: bus_a.wr_en = 1'b0;
          7: begin
            bus_a.rd_en   = 2'b11;
            bus_a.rd_addr = {5'd3, 5'd3};
          end
          8: begin
            check("busy_rd_valid_a", 64'(bus_a.rd_valid), 64'd0);
            check("busy_rd_valid_b", 64'(bus_b.rd_valid), 64'd0);
            bus_a.rd_en = 2'b00;
          end
          10: bus_a.clear_req = 1'b1;
          11: bus_a.clear_req = 1'b0;
          default: ;
        endcase
      end
      if (!bus_a.busy && !bus_b.busy) break;
    end
    @(posedge clk); #1;
  endtask

  task automatic read_all_zero(input string tag);
    for (int i = 0; i < 32; i++) begin
      do_read(5'(i), 5'(31 - i), 2'b11);
      check({tag, "_a0"}, 64'(bus_a.rd_data[31:0]),  64'd0);
      check({tag, "_a1"}, 64'(bus_a.rd_data[63:32]), 64'd0);
      check({tag, "_b0"}, 64'(bus_b.rd_data[31:0]),  64'd0);
      check({tag, "_b1"}, 64'(bus_b.rd_data[63:32]), 64'd0);
      check({tag, "_vld"}, 64'({bus_a.rd_valid, bus_b.rd_valid}), 64'hF);
    end
  endtask

  initial begin
    rst             = 1'b1;
    bus_a.clear_req = 1'b0;
    bus_a.wr_en     = 1'b0;
    bus_a.wr_addr   = '0;
    bus_a.wr_data   = '0;
    bus_a.rd_en     = '0;
    bus_a.rd_addr   = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy_a",  64'(bus_a.busy), 64'd1);
    check("rst_busy_b",  64'(bus_b.busy), 64'd1);
    check("rst_valid_a", 64'(bus_a.rd_valid), 64'd0);
    check("rst_data_a",  64'(bus_a.rd_data), 64'd0);
    check("rst_data_b",  64'(bus_b.rd_data), 64'd0);

    rst = 1'b0;
    count_busy(1'b0, ca, cb);
    check("rst_clr_len_a", 64'(ca), 64'd32);
    check("rst_clr_len_b", 64'(cb), 64'd20);
    read_all_zero("post_rst");

    // basic write then one-cycle read
    do_write(5'd5, 32'hDEADBEEF);
    do_read(5'd5, 5'd0, 2'b01);
    check("rd5_a0",   64'(bus_a.rd_data[31:0]), 64'hDEADBEEF);
    check("rd5_b0",   64'(bus_b.rd_data[31:0]), 64'hDEADBEEF);
    check("rd5_vld_a", 64'(bus_a.rd_valid), 64'd1);
    @(posedge clk); #1;
    check("idle_vld_a",  64'(bus_a.rd_valid), 64'd0);
    check("idle_hold_a", 64'(bus_a.rd_data[31:0]), 64'hDEADBEEF);

    // write-first bypass on both ports
    bus_a.wr_en   = 1'b1;
    bus_a.wr_addr = 5'd7;
    bus_a.wr_data = 32'h12345678;
    bus_a.rd_en   = 2'b11;
    bus_a.rd_addr = {5'd7, 5'd7};
    @(posedge clk); #1;
    bus_a.wr_en = 1'b0;
    bus_a.rd_en = 2'b00;
    check("byp_a0", 64'(bus_a.rd_data[31:0]),  64'h12345678);
    check("byp_a1", 64'(bus_a.rd_data[63:32]), 64'h12345678);
    check("byp_b0", 64'(bus_b.rd_data[31:0]),  64'h12345678);
    check("byp_b1", 64'(bus_b.rd_data[63:32]), 64'h12345678);

    // ports read different addresses independently
    do_read(5'd7, 5'd5, 2'b11);
    check("indep_a0", 64'(bus_a.rd_data[31:0]),  64'h12345678);
    check("indep_a1", 64'(bus_a.rd_data[63:32]), 64'hDEADBEEF);

    // zero register, stored and bypassed
    do_write(5'd0, 32'hFFFFFFFF);
    do_read(5'd0, 5'd0, 2'b11);
    check("zero_a0", 64'(bus_a.rd_data[31:0]),  64'd0);
    check("zero_b1", 64'(bus_b.rd_data[63:32]), 64'd0);
    bus_a.wr_en   = 1'b1;
    bus_a.wr_addr = 5'd0;
    bus_a.wr_data = 32'hFFFFFFFF;
    bus_a.rd_en   = 2'b01;
    bus_a.rd_addr = {5'd0, 5'd0};
    @(posedge clk); #1;
    bus_a.wr_en = 1'b0;
    bus_a.rd_en = 2'b00;
    check("zero_byp_a0", 64'(bus_a.rd_data[31:0]), 64'd0);

    // address 25 exists in the 32-deep file only
    do_write(5'd25, 32'hCAFEF00D);
    do_read(5'd25, 5'd25, 2'b11);
    check("oor_a1",  64'(bus_a.rd_data[63:32]), 64'hCAFEF00D);
    check("oor_b1",  64'(bus_b.rd_data[63:32]), 64'd0);
    check("oor_vld_b", 64'(bus_b.rd_valid), 64'h3);
    bus_a.wr_en   = 1'b1;
    bus_a.wr_addr = 5'd26;
    bus_a.wr_data = 32'h00000055;
    bus_a.rd_en   = 2'b01;
    bus_a.rd_addr = {5'd0, 5'd26};
    @(posedge clk); #1;
    bus_a.wr_en = 1'b0;
    bus_a.rd_en = 2'b00;
    check("oor_byp_a0", 64'(bus_a.rd_data[31:0]), 64'h55);
    check("oor_byp_b0", 64'(bus_b.rd_data[31:0]), 64'd0);

    // clear with a second request mid-sequence and writes while busy
    do_write(5'd3, 32'h0BADC0DE);
    do_read(5'd3, 5'd0, 2'b01);
    check("pre_clr_a0", 64'(bus_a.rd_data[31:0]), 64'h0BADC0DE);
    bus_a.clear_req = 1'b1;
    @(posedge clk); #1;
    bus_a.clear_req = 1'b0;
    count_busy(1'b1, ca, cb);
    check("clr_len_a", 64'(ca), 64'd32);
    check("clr_len_b", 64'(cb), 64'd20);
    read_all_zero("post_clr");

    do_write(5'd9, 32'h13579BDF);
    do_read(5'd9, 5'd9, 2'b11);
    check("rd9_a0", 64'(bus_a.rd_data[31:0]),  64'h13579BDF);
    check("rd9_b1", 64'(bus_b.rd_data[63:32]), 64'h13579BDF);

    // reset in the middle of a clear
    bus_a.clear_req = 1'b1;
    @(posedge clk); #1;
    bus_a.clear_req = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_busy_a", 64'(bus_a.busy), 64'd1);
    check("mid_rst_busy_b", 64'(bus_b.busy), 64'd1);
    check("mid_rst_data_a", 64'(bus_a.rd_data), 64'd0);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    count_busy(1'b0, ca, cb);
    check("rst2_clr_len_a", 64'(ca), 64'd32);
    check("rst2_clr_len_b", 64'(cb), 64'd20);
    do_read(5'd9, 5'd9, 2'b11);
    check("rst2_rd9_a0", 64'(bus_a.rd_data[31:0]),  64'd0);
    check("rst2_rd9_b1", 64'(bus_b.rd_data[63:32]), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multiport_regfile.md
MULTIPORT_REGFILE -- requirements
Module: multiport_regfile

Interface
REQ-001 Parameter WIDTH, default 32, data word width in bits (1..64).
REQ-002 Parameter DEPTH, default 32, number of entries (2..256; need not be a power of two).
REQ-003 Parameter NREAD, default 2, number of independent read ports (1..4).
REQ-004 Parameter ZERO_REG, default 1, when 1 entry 0 always reads as zero and ignores writes.
REQ-005 Derived AW = clog2(DEPTH), the address width.
REQ-006 Port: clk  in  1  single clock; all state changes on its rising edge.
REQ-007 Port: rst  in  1  reset, asynchronous and active-high.
REQ-008 Port: clear_req  in  1  one-cycle pulse that requests zeroing of every entry.
REQ-009 Port: wr_en  in  1  write strobe.
REQ-010 Port: wr_addr  in  AW  write address.
REQ-011 Port: wr_data  in  WIDTH  write data.
REQ-012 Port: rd_en  in  NREAD  per-port read strobe.
REQ-013 Port: rd_addr  in  NREAD*AW  packed read addresses; port i occupies bits [i*AW +: AW].
REQ-014 Port: rd_data  out  NREAD*WIDTH  packed registered read data; port i occupies bits [i*WIDTH +: WIDTH].
REQ-015 Port: rd_valid  out  NREAD  per-port flag: rd_data for that port is valid this cycle.
REQ-016 Port: busy  out  1  high while the clear sequence runs.

Function
REQ-017 The controller SHALL have two states: CLEAR and READY.
REQ-018 In CLEAR, the controller SHALL write zero to entry clr_ptr each cycle, with clr_ptr counting from 0 to DEPTH-1.
REQ-019 After zeroing entry DEPTH-1, the controller SHALL move to READY on the next edge; the clear sequence therefore takes exactly DEPTH cycles.
REQ-020 In READY, a clear_req SHALL move the controller to CLEAR with clr_ptr=0 on the next edge.
REQ-021 A clear_req received while in CLEAR SHALL be ignored; the sequence SHALL not restart.
REQ-022 busy SHALL be 1 exactly while the state is CLEAR.
REQ-023 While busy=1, user writes SHALL be dropped and rd_valid SHALL be 0 on all ports.
REQ-024 In READY, a write with wr_en=1 SHALL update the entry on the rising edge.
REQ-025 Read latency SHALL be one cycle: rd_en[i]=1 at edge N gives rd_data[i] and rd_valid[i]=1 after edge N.
REQ-026 rd_valid[i] SHALL be 0 in the cycle after an edge where rd_en[i]=0.
REQ-027 When rd_en[i]=0, rd_data[i] SHALL hold its previous value.
REQ-028 Write-first bypass: if a read and a write hit the same address on the same edge, the read SHALL return the new wr_data.
REQ-029 When ZERO_REG=1, reads of address 0 SHALL return 0 and writes to address 0 SHALL be dropped, including under bypass.
REQ-030 An address >= DEPTH SHALL read as 0 with rd_valid=1, and a write to it SHALL be dropped.
REQ-031 All NREAD ports SHALL operate independently; reading the same address on several ports in one cycle SHALL be legal.

Reset
REQ-032 While rst=1, the following SHALL hold: state=CLEAR, clr_ptr=0, busy=1, rd_valid=0, rd_data=0.
REQ-033 After rst is released, the full clear sequence (REQ-018 to REQ-019) SHALL run before any write is accepted.
REQ-034 Asserting rst in the middle of a clear or a write SHALL abort it immediately and restart the clear from 0 on release.

Structure
REQ-035 Package multiport_regfile_pkg SHALL hold the state enum (ST_CLEAR, ST_READY) and the default parameter constants.
REQ-036 Each read port SHALL be an instance of sub-module regfile_read_port, which contains the address-range check, zero-register check, bypass mux and output registers.
REQ-037 The storage array SHALL have one write port only; the clear sequence and user writes SHALL share it through a mux selected by the state.

Verification
REQ-038 Reset then release: busy=1 for exactly 32 cycles and then 0; reading every address returns 0x00000000.
REQ-039 Write 0xDEADBEEF to address 5, then read on port 0 at the next edge: rd_data[0]=0xDEADBEEF with rd_valid[0]=1 after one cycle.
REQ-040 On one edge, write 0x12345678 to address 7 and read address 7 on both ports: both ports return 0x12345678 (bypass).
REQ-041 Write 0xFFFFFFFF to address 0 with ZERO_REG=1: a later read of address 0 returns 0. With DEPTH=20, a read of address 25 returns 0.
REQ-042 Assert clear_req after filling entries, then pulse clear_req again 10 cycles in: busy stays high for exactly DEPTH cycles total, all entries read 0, and writes during busy are lost.
REQ-043 Assert rst in cycle 10 of a clear: busy stays 1, and after release the clear takes a full DEPTH cycles again.
